prod_accum: RTL and testbench

Sequential reduction stage directly downstream of the five-lane parallel multiplier top. It captures the five 32-bit products when the multiplier array raises `valid`, then sums them one lane per cycle into a signed accumulator. It presents the result with a one-cycle `valid` pulse and a `busy` level. A one-entry pending slot absorbs a back-to-back batch; a sticky flag records any batch that cannot be accepted.

---
 rtl/prod_accum_pkg.sv | 16 +
 rtl/prod_accum_if.sv | 26 ++
 rtl/prod_accum_sat_add.sv | 26 ++
 rtl/prod_accum.sv | 150 +++++++++++++++
 tb/tb_prod_accum.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the prod_accum reduction stage.
package prod_accum_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_N_LANES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/prod_accum_if.sv
// Batch input / result output bundle between the multiplier top and prod_accum.
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int WIDTH   = DEF_WIDTH
);
  logic [N_LANES*WIDTH-1:0] x_in;
  logic                     in_valid;
  logic                     acc_clr;
  logic [WIDTH-1:0]         sum_out;
  logic                     valid;
  logic                     busy;
  logic                     drop;
  logic                     sat;

  modport master (
    output x_in, in_valid, acc_clr,
    input  sum_out, valid, busy, drop, sat
  );

  modport slave (
    input  x_in, in_valid, acc_clr,
    output sum_out, valid, busy, drop, sat
  );
endinterface

// File: rtl/prod_accum_sat_add.sv
// Combinational signed adder with overflow flag; clamps to the signed range
// when PROD_ACCUM_SAT_EN is defined, otherwise wraps.
module sat_add
  import prod_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);
  logic [WIDTH-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef PROD_ACCUM_SAT_EN
  // Top bits of the package extremes give the extremes for any narrower width.
  localparam logic [WIDTH-1:0] MAX_V = SAT_MAX[DEF_WIDTH-1 -: WIDTH];
  localparam logic [WIDTH-1:0] MIN_V = SAT_MIN[DEF_WIDTH-1 -: WIDTH];
  assign sum = !ovf ? raw : (a[WIDTH-1] ? MIN_V : MAX_V);
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/prod_accum.sv
// Sequential lane-by-lane reducer with a one-entry pending slot.
// Saturating additions when PROD_ACCUM_SAT_EN is defined; wrapping otherwise.
//   state | meaning
//   IDLE  | waiting for a batch (or a batch parked in the pending slot)
//   ACC   | adding lane[idx] into acc, one lane per cycle
//   DONE  | result valid on sum_out; chain the pending batch if present
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  prod_accum_if.slave bus
);
  localparam int IDX_W = $clog2(N_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);
`ifdef PROD_ACCUM_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t                   state_q, state_d;
  logic [N_LANES*WIDTH-1:0] lane_q, lane_d;
  logic [N_LANES*WIDTH-1:0] pend_x_q, pend_x_d;
  logic [N_LANES*WIDTH-1:0] cap_x;
  logic [WIDTH-1:0]         acc_q, acc_d;
  logic [WIDTH-1:0]         sum_q, sum_d;
  logic [WIDTH-1:0]         add_b, add_sum;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     pend_full_q, pend_full_d;
  logic                     pend_clr_q, pend_clr_d;
  logic                     drop_q, drop_d;
  logic                     sat_q, sat_d;
  logic                     add_ovf;
  logic                     cap, cap_clr;

  assign add_b = lane_q[idx_q*WIDTH +: WIDTH];

  sat_add #(.WIDTH(WIDTH)) u_sat_add (
    .a   (acc_q),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    pend_full_d = pend_full_q;
    pend_x_d    = pend_x_q;
    pend_clr_d  = pend_clr_q;
    drop_d      = drop_q;
    sat_d       = sat_q;
    cap         = 1'b0;
    cap_x       = pend_x_q;
    cap_clr     = pend_clr_q;

    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          cap         = 1'b1;
          pend_full_d = 1'b0;
        end else if (bus.in_valid) begin
          cap     = 1'b1;
          cap_x   = bus.x_in;
          cap_clr = bus.acc_clr;
        end
      end
      ACC: begin
        acc_d = add_sum;
        sat_d = sat_q | (add_ovf & SAT_EN);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = add_sum;
          idx_d   = '0;
        end
      end
      DONE: begin
        if (pend_full_q) begin
          cap         = 1'b1;
          pend_full_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap) begin
      lane_d  = cap_x;
      acc_d   = cap_clr ? '0 : sum_q;
      idx_d   = '0;
      state_d = ACC;
      if (cap_clr) begin
        drop_d = 1'b0;
        sat_d  = 1'b0;
      end
    end

    // A discard on the same edge as a clearing capture leaves drop set.
    if (bus.in_valid) begin
      if (state_q != IDLE && pend_full_q) begin
        drop_d = 1'b1;
      end else if (state_q != IDLE || pend_full_q) begin
        pend_full_d = 1'b1;
        pend_x_d    = bus.x_in;
        pend_clr_d  = bus.acc_clr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      pend_full_q <= 1'b0;
      pend_x_q    <= '0;
      pend_clr_q  <= 1'b0;
      drop_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      pend_full_q <= pend_full_d;
      pend_x_q    <= pend_x_d;
      pend_clr_q  <= pend_clr_d;
      drop_q      <= drop_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.sum_out = sum_q;
  assign bus.valid   = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.drop    = drop_q;
  assign bus.sat     = sat_q;
endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: vector table, directed corner sequences,
// and a randomized run against a timestamp-based batch model.
module tb_prod_accum;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int NR = 400;
`ifdef PROD_ACCUM_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef struct {
    string        nm;
    logic [N*W-1:0] x;
    logic         clr;
    logic [W-1:0] exp_sum;
    logic         exp_sat;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    int           at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  prod_accum_if bus ();
  prod_accum dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // model state for the randomized run
  int           busy_end = -100;
  bit           pv = 1'b0;
  logic [N*W-1:0] px;
  logic         pc;
  logic [W-1:0] m_last;
  bit           m_drop = 1'b0;
  bit           m_sat = 1'b0;
  exp_t         exp_q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack5(input logic [W-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [W-1:0] model_sum(input logic [W-1:0] base,
                                             input logic [N*W-1:0] x, output bit ov);
    longint s;
    longint mx = 64'sd2147483647;
    longint mn = -64'sd2147483648;
    logic [W-1:0] lane;
    s  = longint'($signed(base));
    ov = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane = x[i*W +: W];
      s = s + longint'($signed(lane));
      if (SAT_ON) begin
        if (s > mx) begin s = mx; ov = 1'b1; end
        else if (s < mn) begin s = mn; ov = 1'b1; end
      end else begin
        s = longint'($signed(s[W-1:0]));
      end
    end
    return s[W-1:0];
  endfunction

  task automatic model_capture(input int n, input logic [N*W-1:0] x, input logic clr);
    bit ov;
    logic [W-1:0] s;
    if (clr) begin
      m_drop = 1'b0;
      m_sat  = 1'b0;
    end
    s = model_sum(clr ? '0 : m_last, x, ov);
    if (ov) m_sat = 1'b1;
    m_last   = s;
    busy_end = n + N + 1;
    exp_q.push_back('{sum: s, at: busy_end});
  endtask

  task automatic observe(input int n);
    bit   want;
    exp_t e;
    want = (exp_q.size() > 0) && (exp_q[0].at == n);
    chk("rnd_valid", {31'd0, bus.valid}, {31'd0, want});
    if (want) begin
      e = exp_q.pop_front();
      if (bus.valid) chk("rnd_sum", bus.sum_out, e.sum);
    end
  endtask

  task automatic run_batch(input logic [N*W-1:0] x, input logic clr,
                           output logic [W-1:0] sum, output int lat, output int bcnt,
                           output logic vnext);
    @(negedge clk);
    bus.x_in = x; bus.acc_clr = clr; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = -1; bcnt = 0; sum = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.valid) begin
        lat = i;
        sum = bus.sum_out;
        break;
      end
    end
    @(negedge clk);
    if (bus.busy) bcnt++;
    vnext = bus.valid;
  endtask

  vec_t         tbl[8];
  logic [W-1:0] s;
  int           lat, bc, vc, gap;
  logic         vn;
  int           v_cyc[2];
  logic [W-1:0] v_sum[2];
  logic [N*W-1:0] rx;
  logic         rclr, riv;
  bit           idle, had_p;

  initial begin
    tbl[0] = '{"basic",      pack5(1, 2, 3, 4, 5), 1'b1, 32'd15, 1'b0};
    tbl[1] = '{"accum",      pack5(10, 10, 10, 10, 10), 1'b0, 32'd65, 1'b0};
    tbl[2] = '{"clr_zero",   pack5(0, 0, 0, 0, 0), 1'b1, 32'd0, 1'b0};
    tbl[3] = '{"pos_ovf",    pack5(32'h7FFFFFFF, 1, 0, 0, 0), 1'b1,
               SAT_ON ? 32'h7FFFFFFF : 32'h80000000, SAT_ON};
    tbl[4] = '{"sat_sticky", pack5(0, 0, 0, 0, 0), 1'b0,
               SAT_ON ? 32'h7FFFFFFF : 32'h80000000, SAT_ON};
    tbl[5] = '{"negative",   pack5(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1, 32'hFFFFFFFB, 1'b0};
    tbl[6] = '{"neg_ovf",    pack5(32'h80000000, 32'hFFFFFFFF, 0, 0, 0), 1'b1,
               SAT_ON ? 32'h80000000 : 32'h7FFFFFFF, SAT_ON};
    tbl[7] = '{"per_add",    pack5(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000,
               32'h80000000, 5), 1'b1, SAT_ON ? 32'h80000005 : 32'h00000003, SAT_ON};

    reset = 1'b0; bus.in_valid = 1'b0; bus.acc_clr = 1'b0; bus.x_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sum", bus.sum_out, 0);
    chk("rst_valid", {31'd0, bus.valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_drop", {31'd0, bus.drop}, 0);
    chk("rst_sat", {31'd0, bus.sat}, 0);
    reset = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run_batch(tbl[k].x, tbl[k].clr, s, lat, bc, vn);
      chk({tbl[k].nm, "_sum"}, s, tbl[k].exp_sum);
      chk({tbl[k].nm, "_lat"}, lat, 6);
      chk({tbl[k].nm, "_busy"}, bc, 6);
      chk({tbl[k].nm, "_pulse"}, {31'd0, vn}, 0);
      chk({tbl[k].nm, "_sat"}, {31'd0, bus.sat}, {31'd0, tbl[k].exp_sat});
    end

    // back-to-back chaining, then an overflow of the pending slot
    vc = 0; gap = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (vc < 2 && !bus.busy) gap = 1;
        if (bus.valid) begin
          if (vc < 2) begin v_cyc[vc] = n; v_sum[vc] = bus.sum_out; end
          vc++;
        end
      end
      bus.in_valid = (n == 0 || n == 2 || n == 3);
      bus.acc_clr  = (n == 0);
      bus.x_in     = (n == 0) ? pack5(1, 1, 1, 1, 1) :
                     (n == 2) ? pack5(2, 2, 2, 2, 2) : pack5(9, 9, 9, 9, 9);
    end
    chk("b2b_count", vc, 2);
    chk("b2b_t0", v_cyc[0], 6);
    chk("b2b_t1", v_cyc[1], 12);
    chk("b2b_sum0", v_sum[0], 5);
    chk("b2b_sum1", v_sum[1], 15);
    chk("b2b_busy_gap", gap, 0);
    chk("ovf_drop", {31'd0, bus.drop}, 1);
    run_batch(pack5(3, 3, 3, 3, 3), 1'b1, s, lat, bc, vn);
    chk("drop_clr_sum", s, 15);
    chk("drop_clr", {31'd0, bus.drop}, 0);

    // reset in the middle of a batch with a pending batch parked
    run_batch(pack5(10, 10, 10, 10, 10), 1'b1, s, lat, bc, vn);
    chk("pre_rst_sum", s, 50);
    @(negedge clk);
    bus.x_in = pack5(1, 2, 3, 4, 5); bus.acc_clr = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.x_in = pack5(7, 7, 7, 7, 7); bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy}, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_sum", bus.sum_out, 0);
    chk("mid_rst_valid", {31'd0, bus.valid}, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_drop", {31'd0, bus.drop}, 0);
    chk("mid_rst_sat", {31'd0, bus.sat}, 0);
    @(negedge clk);
    reset = 1'b1;
    vc = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) vc++;
    end
    chk("post_rst_quiet", vc, 0);
    run_batch(pack5(1, 2, 3, 4, 5), 1'b0, s, lat, bc, vn);
    chk("post_rst_sum", s, 15);
    chk("post_rst_lat", lat, 6);

    // randomized traffic against the batch model
    m_last = 32'd15;
    for (int n = 0; n < NR + 20; n++) begin
      @(negedge clk);
      observe(n);
      riv  = (n < NR) && ($urandom_range(0, 3) == 0);
      rclr = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        rx[i*W +: W] = $urandom_range(0, 1) ? $urandom() : W'($urandom_range(0, 100));
      bus.in_valid = riv; bus.acc_clr = rclr; bus.x_in = rx;
      idle  = (n > busy_end);
      had_p = pv;
      if (pv && n >= busy_end) begin
        model_capture(n, px, pc);
        pv = 1'b0;
      end
      if (riv) begin
        if (idle && !had_p) model_capture(n, rx, rclr);
        else if (had_p && !idle) m_drop = 1'b1;
        else begin pv = 1'b1; px = rx; pc = rclr; end
      end
    end
    chk("rnd_left", exp_q.size(), 0);
    chk("rnd_drop", {31'd0, bus.drop}, {31'd0, m_drop});
    chk("rnd_sat", {31'd0, bus.sat}, {31'd0, m_sat});
    chk("rnd_last", bus.sum_out, m_last);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
